// File: rtl/host_launch_ctrl.sv
// host_launch_ctrl
//   Runs one accelerator kernel launch over the AXI-lite bridge host port:
//   writes NUM_ARGS argument registers, writes ap_start to the control
//   register, then polls the control register until ap_done (bit 1) is set
//   or MAX_POLLS polls have gone by. The result is reported on a
//   valid/ready done channel.
//
// Ports
//   clock, reset         : clock; synchronous active-high reset
//   launch_valid/ready   : command handshake (ready only while idle)
//   launch_args          : argument i at [i*HOST_DATA_BITS +: HOST_DATA_BITS]
//   done_valid/ready     : completion report, held until accepted
//   done_timeout         : 1 = poll budget ran out, 0 = ap_done seen
//   poll_count           : completed polls of the current or last launch
//   host_req_*           : bridge request (held stable until host_req_deq)
//   host_resp_valid/bits : bridge read data, single-cycle pulse
module host_launch_ctrl #(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int NUM_ARGS       = 2,
    parameter int ARG_BASE       = 'h10,
    parameter int ARG_STRIDE     = 'h08,
    parameter int CTRL_ADDR      = 'h00,
    parameter int POLL_GAP       = 4,
    parameter int MAX_POLLS      = 1000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               launch_valid,
    output logic                               launch_ready,
    input  logic [NUM_ARGS*HOST_DATA_BITS-1:0] launch_args,
    output logic                               done_valid,
    input  logic                               done_ready,
    output logic                               done_timeout,
    output logic [15:0]                        poll_count,
    output logic                               host_req_valid,
    output logic                               host_req_opcode,
    output logic [HOST_ADDR_BITS-1:0]          host_req_addr,
    output logic [HOST_DATA_BITS-1:0]          host_req_value,
    input  logic                               host_req_deq,
    input  logic                               host_resp_valid,
    input  logic [HOST_DATA_BITS-1:0]          host_resp_bits
);

    localparam int IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ARG,
        S_WR_START,
        S_RD_CTRL,
        S_WAIT_RESP,
        S_GAP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic                      opcode;
        logic [HOST_ADDR_BITS-1:0] addr;
        logic [HOST_DATA_BITS-1:0] value;
    } host_req_t;

    state_t                                   state_q, state_d;
    logic [NUM_ARGS-1:0][HOST_DATA_BITS-1:0]  args_q;
    logic [IDX_W-1:0]                         idx_q;
    logic [GAP_W-1:0]                         gap_q;
    logic [15:0]                              poll_inc;
    logic                                     last_arg;
    logic                                     poll_exhausted;
    logic [HOST_ADDR_BITS-1:0]                arg_addr;
    host_req_t                                req;

    // Only ap_done is looked at; the rest of the read word is don't-care.
    logic resp_unused;
    assign resp_unused = ^{host_resp_bits[HOST_DATA_BITS-1:2], host_resp_bits[0]};

    assign last_arg       = (idx_q == IDX_W'(NUM_ARGS - 1));
    assign poll_inc       = (poll_count == 16'hFFFF) ? poll_count : poll_count + 16'd1;
    assign poll_exhausted = (poll_inc == 16'(MAX_POLLS));
    // Wraps modulo the address width, like the bridge address decode.
    assign arg_addr = HOST_ADDR_BITS'(ARG_BASE)
                    + HOST_ADDR_BITS'(idx_q) * HOST_ADDR_BITS'(ARG_STRIDE);

    assign host_req_valid  = req.valid;
    assign host_req_opcode = req.opcode;
    assign host_req_addr   = req.addr;
    assign host_req_value  = req.value;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req          = '0;
        launch_ready = 1'b0;
        done_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                launch_ready = 1'b1;
                if (launch_valid) state_d = S_WR_ARG;
            end
            S_WR_ARG: begin
                req = '{valid: 1'b1, opcode: 1'b1, addr: arg_addr, value: args_q[idx_q]};
                if (host_req_deq && last_arg) state_d = S_WR_START;
            end
            S_WR_START: begin
                req = '{valid: 1'b1, opcode: 1'b1, addr: HOST_ADDR_BITS'(CTRL_ADDR),
                        value: HOST_DATA_BITS'(1)};
                if (host_req_deq) state_d = S_RD_CTRL;
            end
            S_RD_CTRL: begin
                req = '{valid: 1'b1, opcode: 1'b0, addr: HOST_ADDR_BITS'(CTRL_ADDR),
                        value: '0};
                if (host_req_deq) state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (host_resp_valid) begin
                    if (host_resp_bits[1] || poll_exhausted) state_d = S_DONE;
                    else                                     state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Counter hits zero on this cycle's decrement, so the next
                // read shows up POLL_GAP+1 cycles after the response.
                if (gap_q == GAP_W'(1)) state_d = S_RD_CTRL;
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            args_q       <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            poll_count   <= '0;
            done_timeout <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch_valid) begin
                        args_q       <= launch_args;
                        idx_q        <= '0;
                        poll_count   <= '0;
                        done_timeout <= 1'b0;
                    end
                end
                S_WR_ARG: begin
                    if (host_req_deq && !last_arg) idx_q <= idx_q + IDX_W'(1);
                end
                S_WAIT_RESP: begin
                    if (host_resp_valid) begin
                        poll_count <= poll_inc;
                        if (!host_resp_bits[1] && poll_exhausted) done_timeout <= 1'b1;
                        gap_q <= GAP_W'(POLL_GAP);
                    end
                end
                S_GAP: gap_q <= gap_q - GAP_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_launch_ctrl.sv
// Bench for host_launch_ctrl: a bridge model consumes requests with a
// per-launch dequeue delay, answers reads from the launch's response list,
// and checks each consumed request against a queue of expected requests
// filled when the launch is driven.
module tb_host_launch_ctrl;
    localparam int AW = 8, DW = 32, NA = 2, GAP = 4, MAXP = 4;

    logic          clock = 1'b0, reset = 1'b1;
    logic          launch_valid = 1'b0, launch_ready;
    logic [NA*DW-1:0] launch_args = '0;
    logic          done_valid, done_ready = 1'b0, done_timeout;
    logic [15:0]   poll_count;
    logic          host_req_valid, host_req_opcode;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_value;
    logic          host_req_deq = 1'b0, host_resp_valid = 1'b0;
    logic [DW-1:0] host_resp_bits = '0;

    host_launch_ctrl #(.HOST_ADDR_BITS(AW), .HOST_DATA_BITS(DW), .NUM_ARGS(NA),
                       .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .clock(clock), .reset(reset),
        .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_args(launch_args),
        .done_valid(done_valid), .done_ready(done_ready), .done_timeout(done_timeout),
        .poll_count(poll_count),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]       a0, a1;
        int                dly;   // cycles the bridge stalls each request
        logic [3:0][31:0]  resp;  // read data, index 0 = first poll
        bit                to;    // expected done_timeout
        int                pc;    // expected poll_count (= number of reads)
        bit                spur;  // drive stray responses during writes
    } vec_t;

    typedef struct packed {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } req_t;

    req_t exp_q[$];
    vec_t cur;
    int   n_pass = 0, n_tot = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic fail(string name);
        n_tot++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Bridge model and request scoreboard.
    initial begin
        int   wcnt, rd_n, cyc, last_rsp;
        bit   rsp_due;
        req_t held, got, e;
        wcnt = 0; rd_n = 0; cyc = 0; last_rsp = -1; rsp_due = 0;
        held = '0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            host_req_deq    = 1'b0;
            host_resp_valid = 1'b0;
            host_resp_bits  = '0;
            if (launch_ready === 1'b1) begin
                rd_n = 0; last_rsp = -1; wcnt = 0; rsp_due = 0;
            end
            if (rsp_due) begin
                host_resp_valid = 1'b1;
                host_resp_bits  = (rd_n > 3) ? 32'h0 : cur.resp[rd_n];
                rd_n++;
                last_rsp = cyc;
                rsp_due  = 0;
            end else if (cur.spur && host_req_valid && host_req_opcode) begin
                host_resp_valid = 1'b1;
                host_resp_bits  = 32'h2;
            end
            if (host_req_valid === 1'b1) begin
                got = {host_req_opcode, host_req_addr, host_req_value};
                if (wcnt == 0) begin
                    held = got;
                    if (!got.op && last_rsp >= 0)
                        chk("poll_gap", 64'(cyc - last_rsp), 64'(GAP + 1));
                    if (got.op && got.addr == 8'h00)
                        chk("poll_count_at_start", 64'(poll_count), 64'd0);
                end else begin
                    chk("req_stable", 64'(got), 64'(held));
                end
                if (wcnt >= cur.dly) begin
                    host_req_deq = 1'b1;
                    wcnt = 0;
                    if (exp_q.size() == 0) fail("unexpected_req");
                    else begin
                        e = exp_q.pop_front();
                        chk("req_op",   64'(got.op),   64'(e.op));
                        chk("req_addr", 64'(got.addr), 64'(e.addr));
                        chk("req_val",  64'(got.val),  64'(e.val));
                    end
                    if (!got.op) rsp_due = 1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic push_exp(vec_t v);
        exp_q.push_back('{1'b1, 8'h10, v.a0});
        exp_q.push_back('{1'b1, 8'h18, v.a1});
        exp_q.push_back('{1'b1, 8'h00, 32'h1});
        for (int k = 0; k < v.pc; k++) exp_q.push_back('{1'b0, 8'h00, 32'h0});
    endtask

    task automatic start_launch(vec_t v);
        cur = v;
        push_exp(v);
        launch_args  = {v.a1, v.a0};
        launch_valid = 1'b1;
        @(posedge clock); #1;
        launch_valid = 1'b0;
        chk("launch_ready_busy", 64'(launch_ready), 64'd0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            if (done_valid === 1'b1) begin ok = 1; break; end
            @(posedge clock); #1;
        end
        if (!ok) fail("done_wait");
    endtask

    task automatic check_done(vec_t v);
        chk("done_timeout", 64'(done_timeout), 64'(v.to));
        chk("poll_count",   64'(poll_count),   64'(v.pc));
        chk("exp_q_empty",  64'(exp_q.size()), 64'd0);
    endtask

    task automatic finish_launch(vec_t v);
        bit ok;
        wait_done(ok);
        check_done(v);
        done_ready = 1'b1;
        @(posedge clock); #1;
        done_ready = 1'b0;
        chk("launch_ready_after_done", 64'(launch_ready), 64'd1);
        chk("done_valid_after_done",   64'(done_valid),   64'd0);
        chk("poll_count_kept",         64'(poll_count),   64'(v.pc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        n_tot++;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        vec_t tbl[5];
        vec_t va, vb, vr;
        bit   ok;
        tbl[0] = '{32'h11111111, 32'h22222222, 1, {32'h0, 32'h2, 32'h1, 32'h0}, 1'b0, 3, 1'b0};
        tbl[1] = '{32'hDEADBEEF, 32'h0BADF00D, 5, {32'h0, 32'h0, 32'h0, 32'h2}, 1'b0, 1, 1'b0};
        tbl[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 4, 1'b0};
        tbl[3] = '{32'h01234567, 32'h89ABCDEF, 0, {32'h0, 32'h0, 32'h6, 32'h0}, 1'b0, 2, 1'b0};
        tbl[4] = '{32'hCAFEF00D, 32'h13572468, 3, {32'h0, 32'h0, 32'h3, 32'h0}, 1'b0, 2, 1'b1};
        va     = '{32'h33333333, 32'h44444444, 1, {32'h0, 32'h0, 32'h0, 32'h2}, 1'b0, 1, 1'b0};
        vb     = '{32'h55555555, 32'h66666666, 2, {32'h0, 32'h2, 32'h0, 32'h0}, 1'b0, 3, 1'b0};
        vr     = '{32'h77777777, 32'h88888888, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 4, 1'b0};
        cur    = tbl[0];

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_valid",    64'(host_req_valid), 64'd0);
        chk("rst_done_valid",   64'(done_valid),     64'd0);
        chk("rst_done_timeout", 64'(done_timeout),   64'd0);
        chk("rst_poll_count",   64'(poll_count),     64'd0);
        chk("rst_launch_ready", 64'(launch_ready),   64'd1);
        reset = 1'b0;

        foreach (tbl[i]) begin
            start_launch(tbl[i]);
            finish_launch(tbl[i]);
        end

        // Done back-pressure with a competing launch held pending.
        start_launch(va);
        wait_done(ok);
        check_done(va);
        launch_args  = {vb.a1, vb.a0};
        launch_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            chk("hold_done_valid",   64'(done_valid),     64'd1);
            chk("hold_launch_ready", 64'(launch_ready),   64'd0);
            chk("hold_req_valid",    64'(host_req_valid), 64'd0);
        end
        cur = vb;
        push_exp(vb);
        done_ready = 1'b1;
        @(posedge clock); #1;
        done_ready = 1'b0;
        chk("bp_launch_ready_up", 64'(launch_ready), 64'd1);
        chk("bp_done_valid_down", 64'(done_valid),   64'd0);
        @(posedge clock); #1;
        launch_valid = 1'b0;
        chk("bp_launch_taken", 64'(launch_ready), 64'd0);
        finish_launch(vb);

        // Reset while waiting for the first poll response.
        start_launch(vr);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (host_req_valid === 1'b1 && host_req_opcode === 1'b0) begin ok = 1; break; end
            @(posedge clock); #1;
        end
        if (!ok) fail("reach_rd_ctrl");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_req_valid",    64'(host_req_valid), 64'd0);
        chk("midrst_done_valid",   64'(done_valid),     64'd0);
        chk("midrst_launch_ready", 64'(launch_ready),   64'd1);
        chk("midrst_poll_count",   64'(poll_count),     64'd0);
        exp_q.delete();
        start_launch(tbl[0]);
        finish_launch(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
